// File: rtl/wallace_dot_accumulator.sv
// wallace_dot_accumulator
//   Controller and accumulator that sits in front of an external, registered
//   4x4 Wallace multiplier. It accepts unsigned 4-bit operand pairs over a
//   valid/ready handshake and sends each accepted pair to the multiplier. It
//   then sums VEC_LEN returned 8-bit products into one dot-product result and
//   presents that result over a valid/ready handshake.
//
// Ports
//   clk        in   1      rising-edge clock, shared with the multiplier
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      block can accept a pair this cycle
//   in_a/in_b  in   4      operands, unsigned
//   mul_a/b    out  4      operands to multiplier (zero when not issuing)
//   mul_prod   in   8      product from multiplier, MUL_LAT edges after issue
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   out_sum    out  ACC_W  dot-product sum, modulo 2^ACC_W
//   out_ovf    out  1      a carry out of ACC_W occurred in this vector
module wallace_dot_accumulator #(
    parameter int VEC_LEN = 4,
    parameter int MUL_LAT = 2,
    parameter int ACC_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_issue_cnt, r_ret_cnt;
    logic [MUL_LAT-1:0] r_vpipe;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;

    logic               w_acc_en, w_ret, w_ret_last, w_issue_last;
    logic [ACC_W:0]     w_sum;

    assign w_acc_en     = in_valid & in_ready;
    assign w_issue_last = w_acc_en && (r_issue_cnt == LAST);
    // The product leaving the multiplier this cycle belongs to the pair
    // issued MUL_LAT edges ago. Reset clears vpipe, so anything still inside
    // the multiplier at reset is never counted.
    assign w_ret        = r_vpipe[MUL_LAT-1];
    assign w_ret_last   = w_ret && (r_ret_cnt == LAST);
    // Add with one extra bit so the carry out of ACC_W is visible.
    assign w_sum        = {1'b0, r_acc} + {1'b0, ACC_W'(mul_prod)};

    assign mul_a     = w_acc_en ? in_a : 4'd0;
    assign mul_b     = w_acc_en ? in_b : 4'd0;
    assign out_sum   = r_acc;
    assign out_ovf   = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            FILL: begin
                in_ready = 1'b1;
                if (w_issue_last) w_state_nxt = DRAIN;
            end
            DRAIN: ;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = FILL;
            end
            default: w_state_nxt = FILL;
        endcase
        // The final return completes the vector and overrides the issue-side
        // transition.
        if (w_ret_last) w_state_nxt = HOLD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpipe     <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_vpipe <= {r_vpipe[MUL_LAT-2:0], w_acc_en};

            if (w_acc_en) begin
                if (w_issue_last) r_issue_cnt <= '0;
                else              r_issue_cnt <= r_issue_cnt + 1'b1;
            end

            if (w_ret) begin
                if (w_ret_last) r_ret_cnt <= '0;
                else            r_ret_cnt <= r_ret_cnt + 1'b1;

                if (r_ret_cnt == '0) begin
                    // The first product of a vector replaces the previous result.
                    r_acc <= ACC_W'(mul_prod);
                    r_ovf <= 1'b0;
                end else begin
                    r_acc <= w_sum[ACC_W-1:0];
                    r_ovf <= r_ovf | w_sum[ACC_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_wallace_dot_accumulator.sv
module tb_wallace_dot_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = 4'd0, in_b = 4'd0;
    logic       out_ready = 1'b0;

    // DUT with ACC_W=10 and a second one with ACC_W=9, driven in lockstep
    logic       in_ready, out_valid, out_ovf;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_prod;
    logic [9:0] out_sum;

    logic       in_ready9, out_valid9, out_ovf9;
    logic [3:0] mul_a9, mul_b9;
    logic [7:0] mul_prod9;
    logic [8:0] out_sum9;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_hs  = 0;

    always #5 clk = ~clk;

    wallace_dot_accumulator #(.VEC_LEN(4), .MUL_LAT(2), .ACC_W(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_prod(mul_prod), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf));

    wallace_dot_accumulator #(.VEC_LEN(4), .MUL_LAT(2), .ACC_W(9)) dut9 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a9), .mul_b(mul_b9),
        .mul_prod(mul_prod9), .out_valid(out_valid9), .out_ready(out_ready),
        .out_sum(out_sum9), .out_ovf(out_ovf9));

    // Registered two-stage multiplier models with no reset
    logic [7:0] m1, m1_9;
    always @(posedge clk) begin
        m1        <= mul_a * mul_b;
        mul_prod  <= m1;
        m1_9      <= mul_a9 * mul_b9;
        mul_prod9 <= m1_9;
    end

    // Handshakes are sampled mid-cycle; each one completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)   n_acc++;
        if (!rst && out_valid && out_ready) n_hs++;
    end

    // Called at a negedge. Returns at the negedge after the accepting edge, with in_valid low.
    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int guard = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        total++;
        if (!in_ready) begin
            bad++; $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
        total++;
        if (!out_valid) begin
            bad++; $display("FAIL out_timeout out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_sum, out_ovf} !== {1'b1, 1'b0, 10'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state rdy=%0b vld=%0b sum=%0d ovf=%0b required 1 0 0 0",
                     in_ready, out_valid, out_sum, out_ovf);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // T1 + first half of T4: 4x(15,15); latency exactly 2 edges after the last accept
    task automatic test_latency_and_wrap();
        out_ready = 1'b1;
        repeat (4) send(4'd15, 4'd15);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_edge1 out_valid=%0b required 0", out_valid); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_edge2 out_valid=%0b required 0", out_valid); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_sum !== 10'd900 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t1_result vld=%0b sum=%0d ovf=%0b required 1 900 0", out_valid, out_sum, out_ovf);
        end
        total++;
        if (out_valid9 !== 1'b1 || out_sum9 !== 9'd388 || out_ovf9 !== 1'b1) begin
            bad++; $display("FAIL t4_wrap vld=%0b sum=%0d ovf=%0b required 1 388 1", out_valid9, out_sum9, out_ovf9);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL t1_release vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    // T4 second vector: ovf must clear
    task automatic test_ovf_clear();
        int cyc;
        repeat (4) send(4'd1, 4'd1);
        wait_out(cyc);
        total++;
        if (out_sum9 !== 9'd4 || out_ovf9 !== 1'b0 || out_sum !== 10'd4) begin
            bad++; $display("FAIL t4_clear sum9=%0d ovf9=%0b sum=%0d required 4 0 4", out_sum9, out_ovf9, out_sum);
        end
        @(negedge clk);
    endtask

    // T2: consumer stalls for 5 cycles; result held; no accepts during HOLD
    task automatic test_hold();
        int cyc, acc0, hs0;
        out_ready = 1'b0;
        send(4'd1, 4'd2); send(4'd3, 4'd4); send(4'd5, 4'd6); send(4'd7, 4'd8);
        wait_out(cyc);
        acc0 = n_acc; hs0 = n_hs;
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9;   // must not be taken
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_sum !== 10'd100 || in_ready !== 1'b0) begin
                bad++; $display("FAIL t2_hold[%0d] vld=%0b sum=%0d rdy=%0b required 1 100 0",
                                i, out_valid, out_sum, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL t2_release vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
        total++;
        if (n_hs - hs0 !== 1 || n_acc !== acc0) begin
            bad++; $display("FAIL t2_counts hs=%0d acc=%0d required 1 0", n_hs - hs0, n_acc - acc0);
        end
    endtask

    // T3: bubbles of 1-3 cycles between beats
    task automatic test_bubbles();
        int cyc, acc0;
        acc0 = n_acc;
        out_ready = 1'b1;
        send(4'd1, 4'd2); repeat (1) @(negedge clk);
        send(4'd3, 4'd4); repeat (3) @(negedge clk);
        send(4'd5, 4'd6); repeat (2) @(negedge clk);
        send(4'd7, 4'd8);
        wait_out(cyc);
        total++;
        if (out_sum !== 10'd100 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t3_result sum=%0d ovf=%0b required 100 0", out_sum, out_ovf);
        end
        total++;
        if (n_acc - acc0 !== 4) begin
            bad++; $display("FAIL t3_accepts got=%0d required 4", n_acc - acc0);
        end
        @(negedge clk);
    endtask

    // T5: reset after 2 accepts drops in-flight products
    task automatic test_mid_reset();
        int cyc;
        send(4'd2, 4'd3); send(4'd2, 4'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL t5_after_rst vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
        repeat (4) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL t5_stale out_valid=%0b required 0", out_valid); end
        repeat (4) send(4'd2, 4'd3);
        wait_out(cyc);
        total++;
        if (out_sum !== 10'd24 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t5_result sum=%0d ovf=%0b required 24 0", out_sum, out_ovf);
        end
        @(negedge clk);
    endtask

    // T6: back-to-back vectors, out_ready tied high
    task automatic test_back_to_back();
        int cyc;
        out_ready = 1'b1;
        repeat (4) send(4'd1, 4'd1);
        wait_out(cyc);
        total++;
        if (out_sum !== 10'd4) begin bad++; $display("FAIL t6_first sum=%0d required 4", out_sum); end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL t6_ready1 in_ready=%0b required 1", in_ready); end
        repeat (4) send(4'd2, 4'd2);
        wait_out(cyc);
        total++;
        if (out_sum !== 10'd16 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t6_second sum=%0d ovf=%0b required 16 0", out_sum, out_ovf);
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL t6_ready2 rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_latency_and_wrap();
        test_ovf_clear();
        test_hold();
        test_bubbles();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
